press_recorder: RTL and testbench
=================================

Name: press_recorder

Overview:
- Writer-side companion to the Simon Says pattern memory.
- Captures player button presses (12-bit one-hot-ish vectors) into a 256x12 sequence RAM, one entry per complete press/release.
- Exposes a registered read port (en/sel -> btns, 1-cycle latency) that matches the existing pattern-memory read interface, so the game FSM can replay or compare the recorded sequence.

Parameters:
- WIDTH, 12, button vector width.
- DEPTH, 256, number of sequence entries.
- AW, 8, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rec_en  input  1  level; high arms and keeps recording, low stops it.
- clr  input  1  synchronous pulse; empties the sequence.
- btns_in  input  WIDTH  already-synchronised, debounced button levels; 1 = pressed.
- en  input  1  read enable.
- sel  input  AW  read address.
- btns  output  WIDTH  registered read data.
- len  output  AW+1  number of committed entries, 0..DEPTH.
- full  output  1  len == DEPTH.
- recording  output  1  state is ARMED, WAIT_PRESS or HOLD.
- commit  output  1  1-cycle pulse on each memory write.
- err  output  1  1-cycle pulse; see Optional Feature.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - len = 0, btns = 0, accumulator = 0.
  - commit, err, recording, full all 0.
  - Memory contents are not reset.
- States:
  - IDLE -> ARMED when rec_en = 1 and !full.
  - ARMED waits for btns_in == 0, so a press held at arm time is never recorded. -> WAIT_PRESS.
  - WAIT_PRESS: when btns_in != 0, acc <= btns_in -> HOLD.
  - HOLD: each cycle acc <= acc | btns_in. When btns_in == 0 -> COMMIT.
  - COMMIT (one cycle):
    - memory[len[AW-1:0]] <= acc; len <= len + 1; commit = 1.
    - Next state: IDLE if len + 1 == DEPTH (full) or rec_en = 0; else WAIT_PRESS.
- rec_en falling in ARMED or WAIT_PRESS -> IDLE next cycle, no write.
- rec_en falling in HOLD: finish the press; COMMIT still occurs, then IDLE.
- Latency from first released cycle of btns_in to commit pulse: 1 cycle (HOLD sees release, COMMIT next). len updates on the same edge commit drops.
- clr has highest priority, in any state: len <= 0, acc <= 0, state IDLE, no write that cycle. A COMMIT coincident with clr is dropped.
- Full:
  - At len == DEPTH, entry to ARMED is blocked.
  - No wrap-around; len never exceeds DEPTH.
- Read port:
  - On posedge, if en, btns <= memory[sel]; else btns holds.
  - Same-address read during a COMMIT write returns old data (read-first).
  - Reads of addresses >= len return stale contents; no error is flagged.
- Arithmetic: len is AW+1 bits; write address is len[AW-1:0]. All vectors are unsigned.
- Reset mid-press: acc discarded, nothing written, len = 0.

Optional Feature:
- Macro: PRESS_RECORDER_SINGLE_EN
- Defined:
  - In COMMIT, if popcount(acc) != 1 (chord press), no write occurs and len is unchanged.
  - err pulses 1 cycle instead of commit; next-state rules are unchanged.
- Undefined:
  - Any nonzero acc is written.
  - err is tied to 0.

Decomposition:
- Shared package sim_pkg holds:
  - WIDTH/DEPTH/AW defaults as localparams.
  - typedef btn_t (logic [WIDTH-1:0]).
  - typedef enum rec_state_t {IDLE, ARMED, WAIT_PRESS, HOLD, COMMIT}.
- Sub-module seq_ram:
  - 1 write port, 1 registered read port with enable, read-first.
  - Memory array named "memory", DEPTH x WIDTH.
  - The FSM and counters stay in press_recorder.

Test Plan:
- Reset, then rec_en=1, btns_in 0x000 -> 0x004 for 3 cycles -> 0x000:
  - commit pulses 1 cycle after release; len=1.
  - en=1, sel=0 gives btns=0x004 one cycle later.
- Arm while btns_in=0x010 is held, release, then press 0x001:
  - Only 0x001 is recorded at addr 0; len=1.
- Press 0x002, then add 0x008 before release:
  - Macro undefined: memory[0]=0x00A, len=1.
  - Macro defined: err pulse, len=0.
- 256 single presses of 0x001 with rec_en held:
  - full=1 and len=256 after the last commit; recording=0.
  - A 257th press causes no write and len stays 256.
- clr asserted on the COMMIT cycle of the 3rd press:
  - No write; len=0; state IDLE.
  - A following press with rec_en still high re-arms and writes addr 0.
- rst_n low mid-HOLD:
  - Immediately len=0, btns=0, state IDLE.
  - Pre-reset memory entries are still readable after release.

Source files
------------

// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared types and defaults for the press recorder
package sim_pkg;

  localparam int WIDTH = 12;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef logic [WIDTH-1:0] btn_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_PRESS,
    HOLD,
    COMMIT
  } rec_state_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_ram.sv
// rtl/seq_ram.sv - DEPTH x WIDTH sequence RAM, one write port, registered read-first read port
module seq_ram #(
  parameter int WIDTH = sim_pkg::WIDTH,
  parameter int DEPTH = sim_pkg::DEPTH,
  parameter int AW    = sim_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] memory [DEPTH];

  // Contents survive reset so a sequence can be replayed after a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      memory[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= memory[raddr];
    end
  end

endmodule

// File: rtl/press_recorder.sv
// rtl/press_recorder.sv - records complete button presses into a sequence RAM
// PRESS_RECORDER_SINGLE_EN: reject chord presses with an err pulse instead of writing them.
module press_recorder #(
  parameter int WIDTH = sim_pkg::WIDTH,
  parameter int DEPTH = sim_pkg::DEPTH,
  parameter int AW    = sim_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rec_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] btns_in,
  input  logic             en,
  input  logic [AW-1:0]    sel,
  output logic [WIDTH-1:0] btns,
  output logic [AW:0]      len,
  output logic             full,
  output logic             recording,
  output logic             commit,
  output logic             err
);

  import sim_pkg::*;

  rec_state_t       state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [AW:0]      len_n;
  logic             wr_en;
  logic             last_slot;

  assign full      = (len == (AW+1)'(DEPTH));
  assign last_slot = (len == (AW+1)'(DEPTH - 1));
  assign recording = (state == ARMED) || (state == WAIT_PRESS) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      len   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      len   <= len_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    len_n   = len;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    if (clr) begin
      state_n = IDLE;
      acc_n   = '0;
      len_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rec_en && !full) state_n = ARMED;
        end
        // A press already held when arming is ignored until released.
        ARMED: begin
          if (!rec_en)              state_n = IDLE;
          else if (btns_in == '0)   state_n = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!rec_en) begin
            state_n = IDLE;
          end else if (btns_in != '0) begin
            acc_n   = btns_in;
            state_n = HOLD;
          end
        end
        // rec_en is ignored here so an in-progress press is always finished.
        HOLD: begin
          acc_n = acc | btns_in;
          if (btns_in == '0) state_n = COMMIT;
        end
        COMMIT: begin
`ifdef PRESS_RECORDER_SINGLE_EN
          if (popcount(32'(acc)) == 1) begin
            wr_en  = 1'b1;
            commit = 1'b1;
            len_n  = len + 1'b1;
          end else begin
            err = 1'b1;
          end
`else
          wr_en  = 1'b1;
          commit = 1'b1;
          len_n  = len + 1'b1;
`endif
          state_n = (last_slot || !rec_en) ? IDLE : WAIT_PRESS;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  seq_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_seq_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (len[AW-1:0]),
    .wdata (acc),
    .re    (en),
    .raddr (sel),
    .rdata (btns)
  );

endmodule

// File: tb/tb_press_recorder.sv
// tb/tb_press_recorder.sv - directed self-checking bench for press_recorder
module tb_press_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rec_en;
  logic        clr;
  logic [11:0] btns_in;
  logic        en;
  logic [7:0]  sel;
  logic [11:0] btns;
  logic [8:0]  len;
  logic        full;
  logic        recording;
  logic        commit;
  logic        err;

  int checks = 0;
  int errors = 0;

  press_recorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_en    (rec_en),
    .clr       (clr),
    .btns_in   (btns_in),
    .en        (en),
    .sel       (sel),
    .btns      (btns),
    .len       (len),
    .full      (full),
    .recording (recording),
    .commit    (commit),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Precondition: WAIT_PRESS. Ends one cycle after the COMMIT cycle.
  task automatic press(input logic [11:0] v, input int hold);
    btns_in = v;
    repeat (hold) step();
    btns_in = '0;
    step();
    step();
  endtask

  task automatic rd(input logic [7:0] a);
    sel = a;
    en  = 1'b1;
    step();
    en  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    rec_en  = 1'b0;
    clr     = 1'b0;
    btns_in = '0;
    en      = 1'b0;
    sel     = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_len", 16'(len), 16'd0);
    chk("reset_btns", 16'(btns), 16'h000);
    chk("reset_commit", 16'(commit), 16'd0);
    chk("reset_recording", 16'(recording), 16'd0);
    chk("reset_full", 16'(full), 16'd0);
    chk("reset_err", 16'(err), 16'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single press 0x004 held 3 cycles
    rec_en = 1'b1;
    step();
    chk("t1_armed_recording", 16'(recording), 16'd1);
    step();
    btns_in = 12'h004;
    repeat (3) step();
    btns_in = '0;
    chk("t1_no_early_commit", 16'(commit), 16'd0);
    step();
    chk("t1_commit_pulse", 16'(commit), 16'd1);
    chk("t1_len_before", 16'(len), 16'd0);
    step();
    chk("t1_commit_drop", 16'(commit), 16'd0);
    chk("t1_len", 16'(len), 16'd1);
    rec_en = 1'b0;
    step();
    rd(8'd0);
    chk("t1_read0", 16'(btns), 16'h004);

    // Arm while 0x010 is held, then press 0x001
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr_len", 16'(len), 16'd0);
    btns_in = 12'h010;
    rec_en  = 1'b1;
    step();
    step();
    step();
    chk("t2_armed_held", 16'(recording), 16'd1);
    chk("t2_len_held", 16'(len), 16'd0);
    btns_in = '0;
    step();
    press(12'h001, 2);
    chk("t2_len", 16'(len), 16'd1);
    rec_en = 1'b0;
    step();
    rd(8'd0);
    chk("t2_read0", 16'(btns), 16'h001);

    // Chord 0x002 then 0x008 before release
    clr = 1'b1;
    step();
    clr    = 1'b0;
    rec_en = 1'b1;
    step();
    step();
    btns_in = 12'h002;
    step();
    btns_in = 12'h00A;
    step();
    btns_in = '0;
    step();
`ifdef PRESS_RECORDER_SINGLE_EN
    chk("t3_err", 16'(err), 16'd1);
    chk("t3_commit", 16'(commit), 16'd0);
    step();
    chk("t3_len", 16'(len), 16'd0);
`else
    chk("t3_err", 16'(err), 16'd0);
    chk("t3_commit", 16'(commit), 16'd1);
    step();
    chk("t3_len", 16'(len), 16'd1);
`endif
    rec_en = 1'b0;
    step();
    rd(8'd0);
`ifdef PRESS_RECORDER_SINGLE_EN
    chk("t3_read0", 16'(btns), 16'h001);
`else
    chk("t3_read0", 16'(btns), 16'h00A);
`endif

    // Fill all 256 entries
    clr = 1'b1;
    step();
    clr    = 1'b0;
    rec_en = 1'b1;
    step();
    step();
    for (int i = 0; i < 256; i++) begin
      press(12'h001, 1);
    end
    chk("t4_len_full", 16'(len), 16'd256);
    chk("t4_full", 16'(full), 16'd1);
    chk("t4_recording", 16'(recording), 16'd0);
    btns_in = 12'h001;
    step();
    chk("t4_no_rearm", 16'(recording), 16'd0);
    btns_in = '0;
    step();
    chk("t4_no_commit", 16'(commit), 16'd0);
    step();
    chk("t4_len_stays", 16'(len), 16'd256);
    rd(8'd0);
    chk("t4_read0", 16'(btns), 16'h001);
    rd(8'd255);
    chk("t4_read255", 16'(btns), 16'h001);

    // clr on the COMMIT cycle of the 3rd press
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_len", 16'(len), 16'd0);
    chk("t5_clr_full", 16'(full), 16'd0);
    step();
    step();
    press(12'h010, 1);
    press(12'h020, 1);
    chk("t5_len2", 16'(len), 16'd2);
    btns_in = 12'h040;
    step();
    btns_in = '0;
    step();
    chk("t5_commit_pending", 16'(commit), 16'd1);
    clr = 1'b1;
    #1;
    chk("t5_commit_dropped", 16'(commit), 16'd0);
    step();
    clr = 1'b0;
    chk("t5_len_clr", 16'(len), 16'd0);
    chk("t5_idle", 16'(recording), 16'd0);
    step();
    chk("t5_rearm", 16'(recording), 16'd1);
    step();
    press(12'h080, 1);
    chk("t5_len_after", 16'(len), 16'd1);
    rec_en = 1'b0;
    step();
    rd(8'd0);
    chk("t5_read0", 16'(btns), 16'h080);
    rd(8'd2);
    chk("t5_read2_unwritten", 16'(btns), 16'h001);

    // Reset in the middle of a press
    rec_en = 1'b1;
    step();
    step();
    btns_in = 12'h100;
    step();
    step();
    chk("t6_hold", 16'(recording), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_len", 16'(len), 16'd0);
    chk("t6_rst_btns", 16'(btns), 16'h000);
    chk("t6_rst_recording", 16'(recording), 16'd0);
    rst_n   = 1'b1;
    rec_en  = 1'b0;
    btns_in = '0;
    step();
    chk("t6_len_after", 16'(len), 16'd0);
    rd(8'd0);
    chk("t6_read0", 16'(btns), 16'h080);
    rd(8'd1);
    chk("t6_read1", 16'(btns), 16'h020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
